// File: rtl/fifo_rd_drain.sv
// Read-side FIFO consumer: pops on rd_en/empty and re-streams words through a 2-entry skid buffer.
// Optional drop counter enabled by defining RD_DROP_CNT_EN.
module fifo_rd_drain #(
  parameter int unsigned Data_Width = 8,
  parameter int unsigned Cnt_Width  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rstn,
  input  logic                  empty,
  output logic                  rd_en,
  input  logic [Data_Width-1:0] fifo_data_out,
  input  logic                  enable,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [Data_Width-1:0] m_data,
  output logic                  busy,
  output logic                  flush_done,
  output logic [Cnt_Width-1:0]  rd_count
`ifdef RD_DROP_CNT_EN
  ,
  output logic [Cnt_Width-1:0]  drop_count
`endif
);

  typedef enum logic [1:0] {StIdle, StStream, StStop, StFlush} state_e;

  state_e                r_state;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [Data_Width-1:0] r_e0;
  logic [Data_Width-1:0] r_e1;
  logic                  r_flush_done;
  logic [Cnt_Width-1:0]  r_rd_count;

  logic                  w_pop;
  logic                  w_cap;
  logic                  w_flush_entry;
  logic [1:0]            w_occ_after_pop;
  logic [1:0]            w_occ_nxt;
  logic [Data_Width-1:0] w_e0_nxt;
  logic [Data_Width-1:0] w_e1_nxt;

  assign m_valid         = (r_occ != 2'd0) && (r_state != StFlush);
  assign m_data          = r_e0;
  assign busy            = (r_state != StIdle);
  assign flush_done      = r_flush_done;
  assign rd_count        = r_rd_count;
  assign w_pop           = m_valid && m_ready;
  assign w_flush_entry   = flush && (r_state != StFlush);
  assign w_cap           = r_inflight && (r_state != StFlush);
  assign w_occ_after_pop = r_occ - {1'b0, w_pop};

  // Credit rule: never request more than the skid buffer can absorb after this cycle's pop.
  always_comb begin
    rd_en = 1'b0;
    case (r_state)
      StStream: rd_en = !empty &&
                        (({1'b0, r_occ} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop}));
      StFlush:  rd_en = !empty;
      default:  rd_en = 1'b0;
    endcase
  end

  always_comb begin
    w_e0_nxt  = r_e0;
    w_e1_nxt  = r_e1;
    w_occ_nxt = w_occ_after_pop + {1'b0, w_cap};
    if (w_pop) w_e0_nxt = r_e1;
    if (w_cap) begin
      if (w_occ_after_pop == 2'd0) w_e0_nxt = fifo_data_out;
      else                         w_e1_nxt = fifo_data_out;
    end
    if (w_flush_entry) w_occ_nxt = 2'd0;
  end

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_e0       <= '0;
      r_e1       <= '0;
      r_rd_count <= '0;
    end else begin
      r_occ      <= w_occ_nxt;
      r_inflight <= rd_en;
      r_e0       <= w_e0_nxt;
      r_e1       <= w_e1_nxt;
      r_rd_count <= r_rd_count + Cnt_Width'(w_pop);
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      r_state      <= StIdle;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      if (w_flush_entry) begin
        r_state <= StFlush;
      end else begin
        case (r_state)
          StIdle:   if (enable) r_state <= StStream;
          StStream: if (!enable) r_state <= StStop;
          StStop: begin
            if (enable) r_state <= StStream;
            else if ((r_occ == 2'd0) && !r_inflight) r_state <= StIdle;
          end
          StFlush: begin
            if (empty && !r_inflight) begin
              r_state      <= StIdle;
              r_flush_done <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

`ifdef RD_DROP_CNT_EN
  logic [1:0]           w_drop_inc;
  logic [Cnt_Width-1:0] r_drop_count;

  // Entries still held after this cycle's pop are lost on flush entry, as is any arriving word.
  assign w_drop_inc = (w_flush_entry ? w_occ_after_pop : 2'd0) +
                      {1'b0, r_inflight && ((r_state == StFlush) || w_flush_entry)};
  assign drop_count = r_drop_count;

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) r_drop_count <= '0;
    else          r_drop_count <= r_drop_count + Cnt_Width'(w_drop_inc);
  end
`endif

endmodule
